tlb_op_ctrl: RTL
================

Name: tlb_op_ctrl

Overview:
- CP0-side initiator for TLB maintenance instructions (TLBR, TLBWI, TLBWR, TLBP) in the MEM stage.
- Latches the CP0 operands, drives a tlb_req_t request and operand bundle into the TLB, then holds the request until tlb_ok.
- Generates the CP0 write-back for TLBR and TLBP, and stalls the pipeline for the duration.
- Owns the CP0 Random register and its interaction with Wired.

Parameters:
TLBEntries, 32, number of TLB entries; index width IW = $clog2(TLBEntries)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
op_valid  in  1  MEM-stage instruction is a TLB op
op  in  tlb_req_t  TLBR/TLBWI/TLBWR/TLBP (NO_REQ ignored)
flush  in  1  exception/ERET flush of the MEM-stage instruction
cp0_index  in  32  CP0 Index
cp0_entryhi  in  32  CP0 EntryHi
cp0_entrylo0  in  32  CP0 EntryLo0
cp0_entrylo1  in  32  CP0 EntryLo1
wired_we  in  1  MTC0 to Wired this cycle
wired_wdata  in  IW  new Wired value
tlb_req  out  tlb_req_t  request to TLB
tlb_info  out  tlb_t  operand bundle to TLB (index, entryhi, entrylo0, entrylo1, pagemask)
tlb_ok  in  1  TLB completion (registered, TLB side)
tlb_res  in  tlb_t  TLB result (TLBR fields, TLBP index)
stall  out  1  hold pipeline
index_we  out  1  write CP0 Index (TLBP)
index_wdata  out  32  {P, 31-IW zeros... , idx}
tlbr_we  out  1  write EntryHi/EntryLo0/EntryLo1/PageMask (TLBR)
entryhi_wdata, entrylo0_wdata, entrylo1_wdata, pagemask_wdata  out  32 each  TLBR results
cp0_random  out  IW  CP0 Random
cp0_wired  out  IW  CP0 Wired

Behaviour:
- Reset values (async, immediate): state IDLE, tlb_req=NO_REQ, tlb_info all zero, stall=0, index_we=0, tlbr_we=0, all wdata=0, cp0_random=TLBEntries-1, cp0_wired=0, flushed flag=0.
- States: IDLE, REQ, WB.
- IDLE:
  - stall = op_valid && op!=NO_REQ && !flush.
  - On that condition, latch op, entryhi, entrylo0, entrylo1 and the index into tlb_info, then go to REQ.
  - Index source: cp0_index[IW-1:0] for TLBR/TLBWI/TLBP; cp0_random for TLBWR, sampled in the accept cycle.
  - op_valid with flush in IDLE: not accepted, no request issued.
- REQ:
  - tlb_req = latched op; tlb_info stable; stall=1.
  - Stay until tlb_ok=1, then go to WB.
  - No timeout; tlb_ok sampled only in REQ.
- WB (one cycle): tlb_req=NO_REQ, stall=0, instruction retires; next state IDLE.
  - TLBP: index_we=1, index_wdata = {tlb_res.index[31], zeros, tlb_res.index[IW-1:0]}; miss gives 0x8000_0000.
  - TLBR: tlbr_we=1, with the wdata taken from tlb_res; pagemask_wdata=0; entryhi_wdata[12:8]=0.
  - TLBWI/TLBWR: no CP0 write.
- tlb_res and tlb_ok are sampled in the same cycle and latched into the wdata registers.
- Nominal latency: accept cycle N, tlb_req visible N+1, tlb_ok at N+2, WB at N+2 or N+3 (registered), stall low in WB.
- Flush while in REQ:
  - The request is not withdrawn; keep driving it until tlb_ok.
  - Set the flushed flag; in WB suppress index_we/tlbr_we.
  - Clear the flag on return to IDLE.
- Random:
  - Each cycle: if wired_we, cp0_wired <= wired_wdata and cp0_random <= TLBEntries-1.
  - Else if cp0_random <= cp0_wired, cp0_random <= TLBEntries-1.
  - Else cp0_random <= cp0_random-1.
  - Random keeps running during REQ; TLBWR uses only the value captured at accept.
  - If Wired >= TLBEntries-1, Random is held at TLBEntries-1.
- wired_we and a TLBWR accept in the same cycle: TLBWR uses the pre-update cp0_random.
- Reset during REQ: request dropped to NO_REQ immediately; no write-back.

Test Plan:
- TLBP hit: cp0_entryhi=0x0040_2005, TLB returns index 7 with tlb_ok two cycles after request -> tlb_req=TLBP for two cycles, stall high 3 cycles, index_we pulse with index_wdata=0x0000_0007.
- TLBP miss: tlb_res.index=0x8000_0000 -> index_wdata=0x8000_0000, tlbr_we=0.
- TLBR index 3: TLB returns entryhi=0x1234_A0FF, entrylo0=0x0000_1F56 -> tlbr_we one cycle, entryhi_wdata=0x1234_A0FF, pagemask_wdata=0.
- Random/Wired: after reset random=31, decrements to 0 and wraps to 31; wired_we=4 in a cycle with random=10 -> next random=31, then counts 30..4 and wraps to 31. TLBWR accepted when random=17 -> tlb_info.index=17 throughout REQ despite Random changing.
- Flush in REQ: TLBR accepted, flush raised in REQ, tlb_ok delayed 5 cycles -> tlb_req held all 5 cycles, WB has tlbr_we=0; flush with op_valid in IDLE -> no request.
- Async reset asserted mid-REQ -> tlb_req=NO_REQ and stall=0 at once; random=31, wired=0.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared request and operand types for the CP0-side TLB maintenance interface.
package tlb_op_ctrl_pkg;

    typedef enum logic [2:0] {
        NO_REQ = 3'd0,
        TLBR   = 3'd1,
        TLBWI  = 3'd2,
        TLBWR  = 3'd3,
        TLBP   = 3'd4
    } tlb_req_t;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] entryhi;
        logic [31:0] entrylo0;
        logic [31:0] entrylo1;
        logic [31:0] pagemask;
    } tlb_t;

endpackage

// File: rtl/tlb_op_ctrl.sv
// MEM-stage initiator for TLBR/TLBWI/TLBWR/TLBP: issues the TLB request, stalls
// until completion, produces CP0 write-back and owns the Random/Wired pair.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int unsigned TLBEntries = 32,
    localparam int unsigned IW = $clog2(TLBEntries)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    input  tlb_req_t       op,
    input  logic           flush,
    input  logic [31:0]    cp0_index,
    input  logic [31:0]    cp0_entryhi,
    input  logic [31:0]    cp0_entrylo0,
    input  logic [31:0]    cp0_entrylo1,
    input  logic           wired_we,
    input  logic [IW-1:0]  wired_wdata,
    output tlb_req_t       tlb_req,
    output tlb_t           tlb_info,
    input  logic           tlb_ok,
    input  tlb_t           tlb_res,
    output logic           stall,
    output logic           index_we,
    output logic [31:0]    index_wdata,
    output logic           tlbr_we,
    output logic [31:0]    entryhi_wdata,
    output logic [31:0]    entrylo0_wdata,
    output logic [31:0]    entrylo1_wdata,
    output logic [31:0]    pagemask_wdata,
    output logic [IW-1:0]  cp0_random,
    output logic [IW-1:0]  cp0_wired
);

    localparam logic [IW-1:0] RAND_MAX = IW'(TLBEntries - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    logic [1:0]    state_q, state_d;
    tlb_req_t      req_q, req_d;
    tlb_t          info_q, info_d;
    logic          flushed_q, flushed_d;
    logic          index_we_q, index_we_d;
    logic          tlbr_we_q, tlbr_we_d;
    logic [31:0]   index_wdata_q, index_wdata_d;
    logic [31:0]   entryhi_wdata_q, entryhi_wdata_d;
    logic [31:0]   entrylo0_wdata_q, entrylo0_wdata_d;
    logic [31:0]   entrylo1_wdata_q, entrylo1_wdata_d;
    logic [IW-1:0] random_q, random_d;
    logic [IW-1:0] wired_q, wired_d;
    logic          accept_c;
    logic          wb_suppress_c;

    assign accept_c      = (state_q == ST_IDLE) && op_valid && (op != NO_REQ) && !flush;
    assign wb_suppress_c = flushed_q || flush;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            req_q            <= NO_REQ;
            info_q           <= '0;
            flushed_q        <= 1'b0;
            index_we_q       <= 1'b0;
            tlbr_we_q        <= 1'b0;
            index_wdata_q    <= '0;
            entryhi_wdata_q  <= '0;
            entrylo0_wdata_q <= '0;
            entrylo1_wdata_q <= '0;
            random_q         <= RAND_MAX;
            wired_q          <= '0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            info_q           <= info_d;
            flushed_q        <= flushed_d;
            index_we_q       <= index_we_d;
            tlbr_we_q        <= tlbr_we_d;
            index_wdata_q    <= index_wdata_d;
            entryhi_wdata_q  <= entryhi_wdata_d;
            entrylo0_wdata_q <= entrylo0_wdata_d;
            entrylo1_wdata_q <= entrylo1_wdata_d;
            random_q         <= random_d;
            wired_q          <= wired_d;
        end
    end

    // Next-state, request and write-back logic
    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        info_d           = info_q;
        flushed_d        = flushed_q;
        index_we_d       = 1'b0;
        tlbr_we_d        = 1'b0;
        index_wdata_d    = index_wdata_q;
        entryhi_wdata_d  = entryhi_wdata_q;
        entrylo0_wdata_d = entrylo0_wdata_q;
        entrylo1_wdata_d = entrylo1_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_d           = op;
                    // TLBWR targets the Random value current in the accept cycle
                    info_d.index    = (op == TLBWR) ? 32'(random_q) : 32'(cp0_index[IW-1:0]);
                    info_d.entryhi  = cp0_entryhi;
                    info_d.entrylo0 = cp0_entrylo0;
                    info_d.entrylo1 = cp0_entrylo1;
                    info_d.pagemask = '0;
                    state_d         = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (tlb_ok) begin
                    req_d   = NO_REQ;
                    state_d = ST_WB;
                    if (req_q == TLBP) begin
                        index_we_d    = !wb_suppress_c;
                        index_wdata_d = {tlb_res.index[31], {(31 - IW){1'b0}}, tlb_res.index[IW-1:0]};
                    end
                    if (req_q == TLBR) begin
                        tlbr_we_d        = !wb_suppress_c;
                        entryhi_wdata_d  = {tlb_res.entryhi[31:13], 5'b0, tlb_res.entryhi[7:0]};
                        entrylo0_wdata_d = tlb_res.entrylo0;
                        entrylo1_wdata_d = tlb_res.entrylo1;
                    end
                end
            end
            ST_WB: begin
                flushed_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = NO_REQ;
            end
        endcase
    end

    // Random counts down from the top entry to Wired, then wraps
    always_comb begin
        wired_d  = wired_q;
        random_d = random_q;
        if (wired_we) begin
            wired_d  = wired_wdata;
            random_d = RAND_MAX;
        end else if (random_q <= wired_q) begin
            random_d = RAND_MAX;
        end else begin
            random_d = random_q - IW'(1);
        end
    end

    assign tlb_req        = req_q;
    assign tlb_info       = info_q;
    assign stall          = (state_q == ST_REQ) || accept_c;
    assign index_we       = index_we_q;
    assign index_wdata    = index_wdata_q;
    assign tlbr_we        = tlbr_we_q;
    assign entryhi_wdata  = entryhi_wdata_q;
    assign entrylo0_wdata = entrylo0_wdata_q;
    assign entrylo1_wdata = entrylo1_wdata_q;
    assign pagemask_wdata = '0;
    assign cp0_random     = random_q;
    assign cp0_wired      = wired_q;

    logic unused_bits;
    assign unused_bits = ^{cp0_index[31:IW], tlb_res.index[30:IW], tlb_res.entryhi[12:8],
                           tlb_res.pagemask};

endmodule
